// File: rtl/keypad_pkg.sv
// Shared types and the key layout for the hex keypad scanner and its
// debounce/writer logic.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAND = 2'd1,
    HELD = 2'd2
  } fsm_state_e;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    ONE   = 2'd1,
    MULTI = 2'd2
  } scan_class_e;

  // Indexed [row][col]; leftmost entry is row 0, column 0.
  localparam logic [0:3][0:3][3:0] KEYMAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

endpackage

// File: rtl/hex_keypad_writer_if.sv
// Digit-write port shared with the seven-segment display block: one-cycle
// write strobe plus hex value and digit index.
interface hex_keypad_writer_if;

  logic       write;
  logic [3:0] num;
  logic [2:0] sel;

  modport master (output write, output num, output sel);
  modport slave  (input  write, input  num, input  sel);

endinterface

// File: rtl/keypad_col_scan.sv
// Column scanner: synchronizes rows, walks the active-low column ring and
// classifies every full 4-column scan as NONE, ONE(code) or MULTI.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 65536
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        scan_done,
  output scan_class_e scan_class,
  output logic [3:0]  code
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       row_meta_r;
  logic [3:0]       row_sync_r;
  logic [3:0]       col_r;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       col_idx_r;
  logic [1:0]       acc_hits_r;
  logic [3:0]       acc_code_r;
  logic             slot_end_s;
  logic [3:0]       row_low_s;
  logic [2:0]       slot_hits_s;
  logic [2:0]       sum_s;
  logic [1:0]       total_s;
  logic [1:0]       slot_row_s;
  logic [3:0]       merged_code_s;

  assign slot_end_s  = (div_r == DIV_LAST);
  assign row_low_s   = ~row_sync_r;
  assign slot_hits_s = 3'(row_low_s[0]) + 3'(row_low_s[1]) + 3'(row_low_s[2]) + 3'(row_low_s[3]);
  assign sum_s       = {1'b0, acc_hits_r} + slot_hits_s;
  // Hit count saturates at 2: anything beyond that is simply MULTI.
  assign total_s       = (sum_s > 3'd2) ? 2'd2 : sum_s[1:0];
  assign merged_code_s = (acc_hits_r == 2'd0) ? KEYMAP[slot_row_s][col_idx_r] : acc_code_r;

  assign col       = col_r;
  assign scan_done = slot_end_s && (col_idx_r == 2'd3);
  assign code      = merged_code_s;

  // Row index of the low row in the current slot (only meaningful for one hit).
  always_comb begin
    slot_row_s = 2'd0;
    if (row_low_s[0]) begin
      slot_row_s = 2'd0;
    end else if (row_low_s[1]) begin
      slot_row_s = 2'd1;
    end else if (row_low_s[2]) begin
      slot_row_s = 2'd2;
    end else if (row_low_s[3]) begin
      slot_row_s = 2'd3;
    end else begin
      slot_row_s = 2'd0;
    end
  end

  // Scan classification from accumulated plus current-slot hits.
  always_comb begin
    case (total_s)
      2'd0:    scan_class = NONE;
      2'd1:    scan_class = ONE;
      default: scan_class = MULTI;
    endcase
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row;
      row_sync_r <= row_meta_r;
    end
  end

  // Slot divider, column ring and per-scan hit accumulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_r      <= '0;
      col_idx_r  <= 2'd0;
      col_r      <= 4'b1110;
      acc_hits_r <= 2'd0;
      acc_code_r <= 4'd0;
    end else if (slot_end_s) begin
      div_r     <= '0;
      col_idx_r <= col_idx_r + 2'd1;
      col_r     <= {col_r[2:0], col_r[3]};
      if (col_idx_r == 2'd3) begin
        acc_hits_r <= 2'd0;
        acc_code_r <= 4'd0;
      end else begin
        acc_hits_r <= total_s;
        acc_code_r <= merged_code_s;
      end
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

endmodule

// File: rtl/hex_keypad_writer.sv
// Hex keypad to display-digit writer: debounces scanned presses and emits one
// {write,num,sel} per press with an auto-advancing cursor. KEYPAD_REPEAT_EN adds auto-repeat.
module hex_keypad_writer
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 65536,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [3:0]           row,
  output logic [3:0]           col,
  hex_keypad_writer_if.master  disp
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_param_check
    $error("hex_keypad_writer: parameter out of range");
  end

  logic        scan_done_s;
  scan_class_e scan_class_s;
  logic [3:0]  code_s;
  fsm_state_e  state_r;
  logic [3:0]  cand_r;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_inc_s;
  logic [2:0]  cursor_r;
  logic        write_r;
  logic [3:0]  num_r;
  logic [2:0]  sel_r;
  logic        one_cand_s;

`ifdef KEYPAD_REPEAT_EN
  localparam int               REP_W    = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS);
  logic [REP_W-1:0] rep_r;
  logic [REP_W-1:0] rep_inc_s;
  assign rep_inc_s = rep_r + REP_W'(1);
`endif

  keypad_col_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_scan (
    .clk        (clk),
    .reset_n    (reset_n),
    .row        (row),
    .col        (col),
    .scan_done  (scan_done_s),
    .scan_class (scan_class_s),
    .code       (code_s)
  );

  assign cnt_inc_s  = cnt_r + 4'd1;
  assign one_cand_s = (scan_class_s == ONE) && (code_s == cand_r);

  assign disp.write = write_r;
  assign disp.num   = num_r;
  assign disp.sel   = sel_r;

  // Debounce FSM, cursor and output registers; write is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      cand_r   <= 4'd0;
      cnt_r    <= 4'd0;
      cursor_r <= 3'd0;
      write_r  <= 1'b0;
      num_r    <= 4'd0;
      sel_r    <= 3'd0;
`ifdef KEYPAD_REPEAT_EN
      rep_r    <= '0;
`endif
    end else begin
      write_r <= 1'b0;
      if (scan_done_s) begin
        case (state_r)
          IDLE: begin
            if (scan_class_s == ONE) begin
              cand_r <= code_s;
              if (DEB_LAST == 4'd1) begin
                state_r  <= HELD;
                cnt_r    <= 4'd0;
                write_r  <= 1'b1;
                num_r    <= code_s;
                sel_r    <= cursor_r;
                cursor_r <= cursor_r + 3'd1;
`ifdef KEYPAD_REPEAT_EN
                rep_r    <= '0;
`endif
              end else begin
                state_r <= CAND;
                cnt_r   <= 4'd1;
              end
            end
          end
          CAND: begin
            if (one_cand_s) begin
              if (cnt_inc_s == DEB_LAST) begin
                state_r  <= HELD;
                cnt_r    <= 4'd0;
                write_r  <= 1'b1;
                num_r    <= cand_r;
                sel_r    <= cursor_r;
                cursor_r <= cursor_r + 3'd1;
`ifdef KEYPAD_REPEAT_EN
                rep_r    <= '0;
`endif
              end else begin
                cnt_r <= cnt_inc_s;
              end
            end else begin
              state_r <= IDLE;
              cnt_r   <= 4'd0;
            end
          end
          HELD: begin
            // Any key still down restarts the release count.
            if (scan_class_s == NONE) begin
              if (cnt_inc_s == DEB_LAST) begin
                state_r <= IDLE;
                cnt_r   <= 4'd0;
              end else begin
                cnt_r <= cnt_inc_s;
              end
            end else begin
              cnt_r <= 4'd0;
            end
`ifdef KEYPAD_REPEAT_EN
            if (one_cand_s) begin
              if (rep_inc_s == REP_LAST) begin
                rep_r    <= '0;
                write_r  <= 1'b1;
                num_r    <= cand_r;
                sel_r    <= cursor_r;
                cursor_r <= cursor_r + 3'd1;
              end else begin
                rep_r <= rep_inc_s;
              end
            end else begin
              rep_r <= '0;
            end
`endif
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_keypad_writer.sv
// Self-checking bench for hex_keypad_writer: keypad matrix model, scan-level
// reference model checked every cycle, and literal per-phase write lists.
module tb_hex_keypad_writer;

  localparam int SCAN = 16;  // 4 slots x SCAN_DIV=4
  localparam int DEB  = 2;
  localparam int REP  = 4;

  localparam int K1 = 0, K2 = 1, K5 = 5, KB = 7, K9 = 10, K0 = 12, KE = 14, KD = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] pressed = 16'h0000;

  hex_keypad_writer_if kif();

  hex_keypad_writer #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_SCANS   (REP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .row     (row),
    .col     (col),
    .disp    (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  logic [3:0] keycode [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (scan-level) ----------------
  int         cyc = 0;
  logic [15:0] snap = 16'h0000;
  bit         released = 1'b1;
  int         cand_len = 0;
  logic [3:0] cand = 4'h0;
  int         none_len = 0;
  int         rep = 0;
  int         cursor = 0;
  logic       m_write = 1'b0;
  logic [3:0] m_num = 4'h0;
  logic [2:0] m_sel = 3'd0;

  task automatic emit(input logic [3:0] c);
    m_write = 1'b1;
    m_num   = c;
    m_sel   = 3'(cursor);
    cursor  = (cursor + 1) % 8;
  endtask

  task automatic model_scan(input logic [15:0] mask);
    int         n;
    logic [3:0] k;
    n = $countones(mask);
    k = 4'h0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = keycode[i];
    if (released) begin
      if (n == 1 && cand_len > 0 && k == cand) cand_len++;
      else if (n == 1 && cand_len == 0) begin cand = k; cand_len = 1; end
      else cand_len = 0;
      if (cand_len == DEB) begin
        emit(cand);
        released = 1'b0; cand_len = 0; none_len = 0; rep = 0;
      end
    end else begin
      if (n == 0) begin
        none_len++;
        if (none_len == DEB) begin released = 1'b1; none_len = 0; cand_len = 0; end
      end else none_len = 0;
`ifdef KEYPAD_REPEAT_EN
      if (n == 1 && k == cand) begin
        rep++;
        if (rep == REP) begin emit(cand); rep = 0; end
      end else rep = 0;
`endif
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      cyc = 0; released = 1'b1; cand_len = 0; none_len = 0; rep = 0; cursor = 0;
      m_write = 1'b0; m_num = 4'h0; m_sel = 3'd0;
    end else begin
      cyc++;
      m_write = 1'b0;
      if (cyc % SCAN == 8) snap = pressed;
      if (cyc % SCAN == 0) model_scan(snap);
    end
  end

  // ---------------- per-cycle compare and write capture ----------------
  logic [6:0] got [$];
  logic [6:0] exp_q [$];

  initial forever begin
    logic [3:0] exp_col;
    @(negedge clk);
    exp_col = ~(4'b0001 << ((cyc / 4) % 4));
    chk("col",   int'(col),       int'(exp_col));
    chk("write", int'(kif.write), int'(m_write));
    chk("num",   int'(kif.num),   int'(m_num));
    chk("sel",   int'(kif.sel),   int'(m_sel));
    if (kif.write) got.push_back({kif.num, kif.sel});
  end

  // ---------------- stimulus ----------------
  task automatic scans(input int n);
    repeat (n * SCAN) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    #2 reset_n = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic ew(input logic [3:0] num, input logic [2:0] sel);
    exp_q.push_back({num, sel});
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk({name, "_write"}, int'(got[i]), int'(exp_q[i]));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_col",   int'(col),       int'(4'b1110));
    chk("rst_write", int'(kif.write), 0);
    chk("rst_num",   int'(kif.num),   0);
    chk("rst_sel",   int'(kif.sel),   0);
    reset_n = 1'b1;

    // Single presses: 5 then B
    pressed = 16'(1) << K5; scans(6);
    pressed = 16'h0;        scans(3);
    pressed = 16'(1) << KB; scans(4);
    pressed = 16'h0;        scans(3);
    ew(4'h5, 3'd0);
`ifdef KEYPAD_REPEAT_EN
    ew(4'h5, 3'd1);
    ew(4'hB, 3'd2);
`else
    ew(4'hB, 3'd1);
`endif
    check_log("single");

    // Bounce on key 9
    pressed = 16'(1) << K9; scans(1);
    pressed = 16'h0;        scans(2);
    for (int i = 0; i < 10; i++) begin
      pressed = (i % 2 == 0) ? (16'(1) << K9) : 16'h0;
      scans(1);
    end
    pressed = 16'h0; scans(2);
    check_log("bounce");

    // Two keys together, then key 1 alone for one scan only
    pressed = (16'(1) << K1) | (16'(1) << K2); scans(8);
    pressed = 16'(1) << K1; scans(1);
    pressed = 16'h0;        scans(2);
    check_log("multi");

    // Cursor wrap after a fresh reset
    do_reset(3);
    for (int i = 0; i < 9; i++) begin
      pressed = 16'(1) << K0; scans(2);
      pressed = 16'h0;        scans(2);
      ew(4'h0, 3'(i % 8));
    end
    check_log("wrap");

    // Reset while E is held
    pressed = 16'(1) << KE; scans(3);
    do_reset(3);
    scans(3);
    pressed = 16'h0; scans(3);
    ew(4'hE, 3'd1);
    ew(4'hE, 3'd0);
    check_log("rst_mid");

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat on D: accepted after 2 scans, then 14 held scans
    pressed = 16'(1) << KD; scans(16);
    pressed = 16'h0;        scans(3);
    ew(4'hD, 3'd1);
    ew(4'hD, 3'd2);
    ew(4'hD, 3'd3);
    ew(4'hD, 3'd4);
    check_log("repeat");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
